// File: rtl/adder_incr_pkg.sv
// Shared elaboration helpers for the adder_incr incrementer slice.
package adder_incr_pkg;

    // Number of doubling stages needed so a prefix span covers w bits.
    function automatic int unsigned prefix_levels(input int unsigned w);
        for (int unsigned n = 0; n < 32; n++) begin
            if ((32'd1 << n) >= w) return n;
        end
        return 32;
    endfunction

endpackage

// File: rtl/adder_incr_if.sv
// Signal bundle for driving or observing one adder_incr instance.
interface adder_incr_if #(parameter int WIDTH = 32);

    logic [WIDTH-1:0] a;
    logic             en;
    logic [WIDTH-1:0] out;
    logic             cout;
    logic [WIDTH-1:0] out_q;
    logic             cout_q;

    modport master (output a, output en, input out, input cout, input out_q, input cout_q);
    modport slave  (input a, input en, output out, output cout, output out_q, output cout_q);

endinterface

// File: rtl/adder_incr_prefix_and.sv
// Log-depth parallel-prefix AND: all_ones_below[i] is 1 when a[i-1:0] is all ones.
module inc_prefix_and
    import adder_incr_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH:0]   all_ones_below
);

    localparam int unsigned LEVELS = prefix_levels(WIDTH);

    // Kogge-Stone style: each stage doubles the span, so bit j ends as &a[j:0].
    always_comb begin
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] nxt;
        int unsigned      stride;
        p      = a;
        nxt    = a;
        stride = 1;
        for (int unsigned k = 0; k < LEVELS; k++) begin
            stride = 32'd1 << k;
            nxt    = p;
            for (int unsigned j = stride; j < WIDTH; j++) begin
                nxt[j] = p[j] & p[j - stride];
            end
            p = nxt;
        end
        all_ones_below = {p, 1'b1};
    end

endmodule

// File: rtl/adder_incr.sv
// Incrementer out = a + en with carry-out, plus a registered copy of both.
module adder_incr
    import adder_incr_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] out,
    input  logic             en,
    output logic             cout,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] out_q,
    output logic             cout_q
);

    logic [WIDTH:0] all_ones_below;

    inc_prefix_and #(.WIDTH(WIDTH)) u_prefix (
        .a              (a),
        .all_ones_below (all_ones_below)
    );

    // A bit flips only when the carry-in reaches it through all-ones below.
    assign out  = a ^ ({WIDTH{en}} & all_ones_below[WIDTH-1:0]);
    assign cout = en & all_ones_below[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            out_q  <= out;
            cout_q <= cout;
        end
    end

endmodule

// File: tb/tb_adder_incr.sv
// Self-checking bench: four widths, directed table, reset sequences, random vs arithmetic model.
module tb_adder_incr;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adder_incr_if #(.WIDTH(1))  i1 ();
    adder_incr_if #(.WIDTH(25)) i25 ();
    adder_incr_if #(.WIDTH(34)) i34 ();
    adder_incr_if #(.WIDTH(64)) i64 ();

    adder_incr #(.WIDTH(1)) dut1 (
        .a(i1.a), .out(i1.out), .en(i1.en), .cout(i1.cout),
        .clk(clk), .rst(rst), .out_q(i1.out_q), .cout_q(i1.cout_q));
    adder_incr #(.WIDTH(25)) dut25 (
        .a(i25.a), .out(i25.out), .en(i25.en), .cout(i25.cout),
        .clk(clk), .rst(rst), .out_q(i25.out_q), .cout_q(i25.cout_q));
    adder_incr #(.WIDTH(34)) dut34 (
        .a(i34.a), .out(i34.out), .en(i34.en), .cout(i34.cout),
        .clk(clk), .rst(rst), .out_q(i34.out_q), .cout_q(i34.cout_q));
    adder_incr #(.WIDTH(64)) dut64 (
        .a(i64.a), .out(i64.out), .en(i64.en), .cout(i64.cout),
        .clk(clk), .rst(rst), .out_q(i64.out_q), .cout_q(i64.cout_q));

    int          W [4] = '{1, 25, 34, 64};
    logic [63:0] got_out  [4];
    logic [63:0] got_q    [4];
    logic        got_cout [4];
    logic        got_cq   [4];

    assign got_out[0] = 64'(i1.out);
    assign got_out[1] = 64'(i25.out);
    assign got_out[2] = 64'(i34.out);
    assign got_out[3] = 64'(i64.out);
    assign got_q[0]   = 64'(i1.out_q);
    assign got_q[1]   = 64'(i25.out_q);
    assign got_q[2]   = 64'(i34.out_q);
    assign got_q[3]   = 64'(i64.out_q);
    assign got_cout[0] = i1.cout;
    assign got_cout[1] = i25.cout;
    assign got_cout[2] = i34.cout;
    assign got_cout[3] = i64.cout;
    assign got_cq[0]   = i1.cout_q;
    assign got_cq[1]   = i25.cout_q;
    assign got_cq[2]   = i34.cout_q;
    assign got_cq[3]   = i64.cout_q;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          w;
        logic [63:0] a;
        logic        en;
        logic [63:0] exp_out;
        logic        exp_cout;
    } vec_t;

    // Reference: the sum of a and en taken at w+1 bits; returns {cout, out}.
    function automatic logic [64:0] ref_sum(input int w, input logic [63:0] a, input logic en);
        logic [63:0] mask;
        logic [64:0] s;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        s    = {1'b0, a & mask} + 65'(en);
        return {s[w], s[63:0] & mask};
    endfunction

    function automatic int idx_of(input int w);
        for (int i = 0; i < 4; i++) if (W[i] == w) return i;
        return 0;
    endfunction

    task automatic chk(input string name, input int w, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s w=%0d got=%h exp=%h", name, w, got, exp);
        end
    endtask

    task automatic drive(input logic [63:0] av, input logic env, input logic rv);
        i1.a  = av[0:0];
        i25.a = av[24:0];
        i34.a = av[33:0];
        i64.a = av;
        i1.en  = env;
        i25.en = env;
        i34.en = env;
        i64.en = env;
        rst    = rv;
    endtask

    vec_t        vecs [12];
    logic [63:0] r;
    logic        e;
    logic        rs;
    logic [64:0] exp_s [4];

    initial begin
        vecs[0]  = '{34, 64'h0,                 1'b1, 64'h1,                 1'b0};
        vecs[1]  = '{34, 64'h3_FFFF_FFFF,       1'b1, 64'h0,                 1'b1};
        vecs[2]  = '{25, 64'h1FF_FFFF,          1'b1, 64'h0,                 1'b1};
        vecs[3]  = '{34, 64'h0_0000_FFFF,       1'b1, 64'h0_0001_0000,       1'b0};
        vecs[4]  = '{34, 64'h1_2345_6789,       1'b0, 64'h1_2345_6789,       1'b0};
        vecs[5]  = '{1,  64'h1,                 1'b1, 64'h0,                 1'b1};
        vecs[6]  = '{1,  64'h0,                 1'b1, 64'h1,                 1'b0};
        vecs[7]  = '{1,  64'h1,                 1'b0, 64'h1,                 1'b0};
        vecs[8]  = '{64, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0,               1'b1};
        vecs[9]  = '{64, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 64'h8000_0000_0000_0000, 1'b0};
        vecs[10] = '{25, 64'h0FF_FFFF,          1'b1, 64'h100_0000,          1'b0};
        vecs[11] = '{25, 64'h1FF_FFFF,          1'b0, 64'h1FF_FFFF,          1'b0};

        // Reset state of the registers.
        drive(64'h0, 1'b0, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            chk("reset_out_q",  W[i], got_q[i], 64'h0);
            chk("reset_cout_q", W[i], 64'(got_cq[i]), 64'h0);
        end

        // Directed table, combinational outputs.
        @(negedge clk);
        for (int v = 0; v < 12; v++) begin
            int k;
            drive(vecs[v].a, vecs[v].en, 1'b1);
            #1;
            k = idx_of(vecs[v].w);
            chk("table_out",  vecs[v].w, got_out[k], vecs[v].exp_out);
            chk("table_cout", vecs[v].w, 64'(got_cout[k]), 64'(vecs[v].exp_cout));
        end

        // a=5, en=1: out_q follows after one edge, reset clears it while out holds.
        @(negedge clk);
        drive(64'h5, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("seq_load_q", 34, got_q[2], 64'h6);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("seq_rst_q",    34, got_q[2], 64'h0);
        chk("seq_rst_cq",   34, 64'(got_cq[2]), 64'h0);
        chk("seq_rst_out",  34, got_out[2], 64'h6);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("seq_resume_q", 34, got_q[2], 64'h6);

        // Carry-out register load, then reset override of a live carry.
        @(negedge clk);
        drive('1, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("seq_cq_load", 25, 64'(got_cq[1]), 64'h1);
        chk("seq_q_wrap",  25, got_q[1], 64'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("seq_cq_rst",   25, 64'(got_cq[1]), 64'h0);
        chk("seq_cout_rst", 25, 64'(got_cout[1]), 64'h1);

        // Random vectors with occasional reset against the arithmetic model.
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            r  = {$urandom(), $urandom()};
            if ($urandom_range(0, 7) == 0) r = '1;
            e  = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 15) == 0);
            drive(r, e, rs);
            #1;
            for (int i = 0; i < 4; i++) begin
                exp_s[i] = ref_sum(W[i], r, e);
                chk("rand_out",  W[i], got_out[i], exp_s[i][63:0]);
                chk("rand_cout", W[i], 64'(got_cout[i]), 64'(exp_s[i][64]));
            end
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                chk("rand_out_q",  W[i], got_q[i], rs ? 64'h0 : exp_s[i][63:0]);
                chk("rand_cout_q", W[i], 64'(got_cq[i]), rs ? 64'h0 : 64'(exp_s[i][64]));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_incr.md
ADDER_INCR -- requirements
Module: adder_incr

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand and result width; legal range 1..64; instantiated at 34 and 25.
REQ-002 clk  input  1  SHALL be the single clock, rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 a  input  WIDTH  SHALL be the operand.
REQ-005 out  output  WIDTH  SHALL be the combinational result, a + en.
REQ-006 en  input  1  SHALL be the increment enable (carry-in); tied to 1 for a plain incrementer.
REQ-007 cout  output  1  SHALL be the combinational carry-out; may be left unconnected.
REQ-008 out_q  output  WIDTH  SHALL be the registered copy of out.
REQ-009 cout_q  output  1  SHALL be the registered copy of cout.
REQ-010 Positional port order SHALL be a, out, en, cout, clk, rst, out_q, cout_q, so the 4-port positional form (a, out, en, cout) stays legal with the trailing ports unconnected.

Function
REQ-011 out SHALL equal (a + en) mod 2^WIDTH, with zero latency and no dependence on clk.
REQ-012 cout SHALL be 1 exactly when en=1 and a is all ones; otherwise 0.
REQ-013 With en=0, out SHALL equal a and cout SHALL be 0.
REQ-014 Bit i of out SHALL be a[i] XOR (en AND all of a[i-1:0]); bit 0 SHALL be a[0] XOR en.
REQ-015 The all-ones-below terms SHALL use a log2(WIDTH)-depth parallel-prefix AND network, not a ripple chain.
REQ-016 Wrap-around: a all ones with en=1 SHALL give out=0 and cout=1.
REQ-017 On each rising clk edge with rst=0, out_q<=out and cout_q<=cout, giving one-cycle latency.
REQ-018 The circuit SHALL have no handshake and no state other than out_q and cout_q.
REQ-019 X or Z on any bit of a SHALL propagate only to out bits at or above that bit position, and to cout.

Reset
REQ-020 When rst=1 at a rising edge, out_q SHALL become 0 and cout_q SHALL become 0.
REQ-021 Reset SHALL NOT affect out or cout, which stay purely combinational.
REQ-022 A rst asserted mid-stream SHALL override the register load in that cycle.
REQ-023 Registered values SHALL resume tracking out and cout on the first edge after rst deasserts.

Structure
REQ-024 No shared package is required.
REQ-025 WIDTH SHALL be the only constant.
REQ-026 The prefix-AND network SHALL be one sub-module, inc_prefix_and, parameterised by WIDTH, with input a and output all_ones_below[WIDTH:0].
REQ-027 all_ones_below[WIDTH] SHALL feed cout.
REQ-028 Top-level logic SHALL be the XOR stage plus the output registers.

Verification
REQ-029 Scenario 1: WIDTH=34, a=0, en=1 -> out=0x1, cout=0.
REQ-030 Scenario 2: WIDTH=34, a=0x3_FFFF_FFFF, en=1 -> out=0, cout=1; WIDTH=25, a=0x1FF_FFFF -> out=0, cout=1.
REQ-031 Scenario 3: WIDTH=34, a=0x0_0000_FFFF, en=1 -> out=0x0_0001_0000; a=0x1_2345_6789, en=0 -> out=0x1_2345_6789, cout=0.
REQ-032 Scenario 4: random a over 10k vectors for WIDTH 1, 25, 34, 64 -> {cout,out} equals a+en computed at WIDTH+1 bits.
REQ-033 Scenario 5: apply a=5, en=1 with rst=0 -> out_q=6 after the next edge; assert rst for one edge -> out_q=0 and cout_q=0 while out stays 6.
